// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings: hazard controls,
// EX redirect, the instruction-memory request/response port and the IF/ID register.
interface fetch_stage_if;
    logic        stall;
    logic        bubble;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    modport master (
        input  stall, bubble, redirect_valid, redirect_pc,
        input  imem_ready, imem_valid, imem_rdata,
        output imem_req, imem_addr,
        output if_id_valid, if_id_pc, if_id_instr
    );

    modport slave (
        output stall, bubble, redirect_valid, redirect_pc,
        output imem_ready, imem_valid, imem_rdata,
        input  imem_req, imem_addr,
        input  if_id_valid, if_id_pc, if_id_instr
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, a 1-entry holding buffer for
// responses that land while decode is stalled, and redirect/flush handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e      state_q;
    logic        req_q;
    logic        drop_q;
    logic [31:0] pc_q;
    logic [31:0] buf_q;
    logic        if_valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_instr_q;

    logic        hold_in;
    logic        rsp_ok;
    logic        take_rsp;
    logic        release_buf;
    logic [31:0] pc_inc;
    logic [31:0] redir_pc;

    assign hold_in     = bus.stall | bus.bubble;
    // A response is usable only if it belongs to the current stream and no redirect kills it.
    assign rsp_ok      = (state_q == WAIT) && bus.imem_valid && !drop_q && !bus.redirect_valid;
    assign take_rsp    = rsp_ok && !hold_in;
    assign release_buf = (state_q == HOLD) && !hold_in && !bus.redirect_valid;
    assign pc_inc      = pc_q + 32'd4;
    assign redir_pc    = {bus.redirect_pc[31:2], 2'b00};

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.if_id_valid = if_valid_q;
    assign bus.if_id_pc    = if_pc_q;
    assign bus.if_id_instr = if_instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            drop_q     <= 1'b0;
            pc_q       <= RESET_PC;
            buf_q      <= NOP_INSTR;
            if_valid_q <= 1'b0;
            if_pc_q    <= RESET_PC;
            if_instr_q <= NOP_INSTR;
        end else begin
            if (bus.redirect_valid)
                pc_q <= redir_pc;
            else if (take_rsp || release_buf)
                pc_q <= pc_inc;

            // Flush wins over stall; IF/ID pc is left alone on a flush.
            if (bus.redirect_valid || bus.bubble) begin
                if_valid_q <= 1'b0;
                if_instr_q <= NOP_INSTR;
            end else if (take_rsp) begin
                if_valid_q <= 1'b1;
                if_pc_q    <= pc_q;
                if_instr_q <= bus.imem_rdata;
            end else if (release_buf) begin
                if_valid_q <= 1'b1;
                if_pc_q    <= pc_q;
                if_instr_q <= buf_q;
            end

            if (rsp_ok && hold_in)
                buf_q <= bus.imem_rdata;

            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    // An accepted request to the stale address must have its response dropped.
                    if (bus.imem_ready) begin
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                        drop_q  <= bus.redirect_valid;
                    end
                end
                WAIT: begin
                    if (bus.imem_valid) begin
                        drop_q <= 1'b0;
                        if (rsp_ok && hold_in) begin
                            state_q <= HOLD;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end else if (bus.redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.redirect_valid || !hold_in) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: memory responder, program-order reference model,
// directed scenarios for start-up, stall/hold, redirect, flush, wrap and reset abandon.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_stage_if b0();
    fetch_stage_if b1();

    fetch_stage u_dut (.clk(clk), .rst_n(rst_n), .bus(b0));
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(b1));

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Program image: address 0 holds the addi x1,x0,10 word, elsewhere a bijective hash.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return (a ^ 32'h1234_5678) * 32'h9E37_79B1;
    endfunction

    // ---------------- memory responder for b0 ----------------
    bit          rand_rdy = 1'b0;
    int          lat_lo = 0, lat_hi = 0;
    bit          force_valid = 1'b0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;

    initial begin
        b0.imem_ready = 1'b0;
        b0.imem_valid = 1'b0;
        b0.imem_rdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            b0.imem_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
                b0.imem_ready = 1'b0;
            end else begin
                if (force_valid) begin
                    b0.imem_valid = 1'b1;
                    b0.imem_rdata = 32'hDEAD_BEEF;
                    force_valid = 1'b0;
                end else if (pend) begin
                    if (cnt == 0) begin
                        b0.imem_valid = 1'b1;
                        b0.imem_rdata = memf(paddr);
                        pend = 1'b0;
                    end else cnt--;
                end
                b0.imem_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : 1'b1;
                if (b0.imem_req && b0.imem_ready) begin
                    pend  = 1'b1;
                    paddr = b0.imem_addr;
                    cnt   = $urandom_range(lat_hi, lat_lo);
                end
            end
        end
    end

    // ---------------- reference model / checker for b0 ----------------
    logic [31:0] exp_pc = 32'h0, p_pc = 32'h0, p_ins = 32'h0, a_rpc;
    logic        p_req = 1'b0, p_vld = 1'b0;
    logic        a_st, a_bb, a_rd, a_rdy, a_val;
    bit          outst = 1'b0;
    int          loads = 0;

    initial begin
        forever begin
            @(posedge clk);
            a_st = b0.stall; a_bb = b0.bubble; a_rd = b0.redirect_valid;
            a_rpc = b0.redirect_pc; a_rdy = b0.imem_ready; a_val = b0.imem_valid;
            #1;
            if (!rst_n) begin
                chk("rst_req",  32'(b0.imem_req), 32'h0);
                chk("rst_addr", b0.imem_addr, 32'h0);
                chk("rst_vld",  32'(b0.if_id_valid), 32'h0);
                chk("rst_pc",   b0.if_id_pc, 32'h0);
                chk("rst_ins",  b0.if_id_instr, NOP);
                exp_pc = 32'h0;
                outst  = 1'b0;
            end else begin
                if (a_val) outst = 1'b0;
                if (p_req && a_rdy) begin
                    chk("one_outstanding", 32'(outst), 32'h0);
                    outst = 1'b1;
                end
                if (a_rd) begin
                    chk("rd_vld", 32'(b0.if_id_valid), 32'h0);
                    chk("rd_ins", b0.if_id_instr, NOP);
                    chk("rd_pc",  b0.if_id_pc, p_pc);
                    exp_pc = a_rpc & ~32'h3;
                end else if (a_bb) begin
                    chk("bb_vld", 32'(b0.if_id_valid), 32'h0);
                    chk("bb_ins", b0.if_id_instr, NOP);
                    chk("bb_pc",  b0.if_id_pc, p_pc);
                end else if (a_st) begin
                    chk("st_vld", 32'(b0.if_id_valid), 32'(p_vld));
                    chk("st_pc",  b0.if_id_pc, p_pc);
                    chk("st_ins", b0.if_id_instr, p_ins);
                end else if (b0.if_id_valid && (!p_vld || b0.if_id_pc != p_pc)) begin
                    chk("ld_pc",  b0.if_id_pc, exp_pc);
                    chk("ld_ins", b0.if_id_instr, memf(exp_pc));
                    exp_pc += 32'd4;
                    loads++;
                end else begin
                    chk("idle_vld", 32'(b0.if_id_valid), 32'(p_vld));
                    chk("idle_ins", b0.if_id_instr, p_ins);
                end
                if (b0.imem_req) chk("req_addr", b0.imem_addr, exp_pc);
            end
            p_req = b0.imem_req; p_vld = b0.if_id_valid;
            p_pc = b0.if_id_pc; p_ins = b0.if_id_instr;
        end
    end

    // ---------------- wrap-around instance: 1-cycle memory, no hazards ----------------
    bit          acc1 = 1'b0, done1 = 1'b0;
    logic [31:0] a1 = 32'h0;

    initial begin
        b1.stall = 1'b0; b1.bubble = 1'b0; b1.redirect_valid = 1'b0; b1.redirect_pc = 32'h0;
        b1.imem_ready = 1'b1; b1.imem_valid = 1'b0; b1.imem_rdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            if (!rst_n) begin
                acc1 = 1'b0;
                b1.imem_valid = 1'b0;
            end else begin
                b1.imem_valid = acc1;
                b1.imem_rdata = memf(a1);
                acc1 = b1.imem_req;
                a1   = b1.imem_addr;
                if (b1.if_id_valid && !done1) begin
                    chk("wrap_pc",   b1.if_id_pc, 32'hFFFF_FFFC);
                    chk("wrap_ins",  b1.if_id_instr, memf(32'hFFFF_FFFC));
                    chk("wrap_req",  32'(b1.imem_req), 32'h1);
                    chk("wrap_next", b1.imem_addr, 32'h0);
                    done1 = 1'b1;
                end
            end
        end
    end

    task automatic wait_sig(input bit which);
        for (int n = 0; n < 50; n++) begin
            if ((which ? b0.if_id_valid : b0.imem_req) === 1'b1) break;
            @(negedge clk);
        end
        chk(which ? "tmo_ifv" : "tmo_req", 32'(which ? b0.if_id_valid : b0.imem_req), 32'h1);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] sv_pc, sv_ins;

    initial begin
        rst_n = 1'b0;
        b0.stall = 1'b0; b0.bubble = 1'b0; b0.redirect_valid = 1'b0; b0.redirect_pc = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // start-up fetch from RESET_PC with a 1-cycle memory
        wait_sig(1'b0);
        chk("t1_addr", b0.imem_addr, 32'h0);
        wait_sig(1'b1);
        chk("t1_pc",   b0.if_id_pc, 32'h0);
        chk("t1_ins",  b0.if_id_instr, 32'h00A0_0093);
        chk("t1_req",  32'(b0.imem_req), 32'h1);
        chk("t1_next", b0.imem_addr, 32'h4);

        // response arrives during a 3-cycle stall -> held, then released
        sv_pc = b0.if_id_pc; sv_ins = b0.if_id_instr;
        b0.stall = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold_req", 32'(b0.imem_req), 32'h0);
        chk("hold_pc",  b0.if_id_pc, sv_pc);
        chk("hold_ins", b0.if_id_instr, sv_ins);
        b0.stall = 1'b0;
        lat_lo = 1; lat_hi = 1;
        @(negedge clk);
        chk("rel_pc",   b0.if_id_pc, sv_pc + 32'd4);
        chk("rel_ins",  b0.if_id_instr, memf(sv_pc + 32'd4));
        chk("rel_addr", b0.imem_addr, sv_pc + 32'd8);

        // redirect while waiting, stale response arrives afterwards
        @(negedge clk);
        b0.redirect_valid = 1'b1; b0.redirect_pc = 32'h0000_0103;
        @(negedge clk);
        b0.redirect_valid = 1'b0;
        lat_lo = 0; lat_hi = 0;
        chk("rd_flush_vld", 32'(b0.if_id_valid), 32'h0);
        wait_sig(1'b0);
        chk("rd_addr",    b0.imem_addr, 32'h0000_0100);
        chk("rd_vld_low", 32'(b0.if_id_valid), 32'h0);

        // bubble together with stall on a valid IF/ID
        wait_sig(1'b1);
        sv_pc = b0.if_id_pc;
        b0.stall = 1'b1; b0.bubble = 1'b1;
        @(negedge clk);
        b0.stall = 1'b0; b0.bubble = 1'b0;
        chk("bs_vld", 32'(b0.if_id_valid), 32'h0);
        chk("bs_ins", b0.if_id_instr, NOP);
        chk("bs_pc",  b0.if_id_pc, sv_pc);
        wait_sig(1'b1);
        chk("bs_next_pc", b0.if_id_pc, sv_pc + 32'd4);

        // reset during WAIT, late response right after release must be ignored
        wait_sig(1'b0);
        @(negedge clk);
        chk("w_req", 32'(b0.imem_req), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        force_valid = 1'b1;
        wait_sig(1'b1);
        chk("rr_pc",  b0.if_id_pc, 32'h0);
        chk("rr_ins", b0.if_id_instr, 32'h00A0_0093);

        // randomized traffic
        rand_rdy = 1'b1; lat_lo = 0; lat_hi = 2;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            b0.stall  = ($urandom_range(0, 99) < 20);
            b0.bubble = ($urandom_range(0, 99) < 8);
            b0.redirect_valid = ($urandom_range(0, 99) < 5);
            b0.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                         : $urandom_range(0, 1023);
        end
        @(negedge clk);
        b0.stall = 1'b0; b0.bubble = 1'b0; b0.redirect_valid = 1'b0;
        repeat (10) @(negedge clk);

        chk("progress",  32'(loads > 200), 32'h1);
        chk("wrap_seen", 32'(done1), 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID when empty or flushed (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  from hazard_detection; hold PC and IF/ID contents.
REQ-006 bubble  input  1  from hazard_detection; flush IF/ID to NOP.
REQ-007 redirect_valid  input  1  branch/jump taken, resolved in EX.
REQ-008 redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-009 imem_req  output  1  instruction memory request valid.
REQ-010 imem_addr  output  32  request word address (byte address, [1:0]=0).
REQ-011 imem_ready  input  1  memory accepts the request this cycle.
REQ-012 imem_valid  input  1  read data valid; at most one response per accepted request, arriving at least one cycle after acceptance.
REQ-013 imem_rdata  input  32  instruction word.
REQ-014 if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-015 if_id_pc  output  32  PC of the IF/ID instruction.
REQ-016 if_id_instr  output  32  IF/ID instruction word.

Function
REQ-017 FSM states: IDLE, REQ, WAIT, HOLD; at most one outstanding memory request at any time.
REQ-018 IDLE: imem_req=0; next cycle go to REQ unconditionally.
REQ-019 REQ: imem_req=1, imem_addr=pc; imem_addr stable until accepted or redirected; imem_ready=1 -> WAIT.
REQ-020 WAIT: imem_req=0; on imem_valid with drop=0 and stall=0 and bubble=0 -> load IF/ID (valid=1, pc, rdata), pc<=pc+4, go REQ.
REQ-021 WAIT: on imem_valid with drop=0 and (stall or bubble) -> capture rdata into a 1-entry holding buffer, go HOLD.
REQ-022 HOLD: imem_req=0; first cycle with stall=0 and bubble=0 -> load IF/ID from buffer, pc<=pc+4, go REQ.
REQ-023 stall=1 (no flush): pc, IF/ID registers and holding buffer unchanged; an in-flight response is still captured per REQ-021.
REQ-024 bubble=1: IF/ID <= {valid=0, pc unchanged, instr=NOP_INSTR}; bubble overrides stall for IF/ID; PC and FSM unaffected except per REQ-021/022.
REQ-025 redirect_valid=1 (highest priority, any state): pc<=redirect_pc&~3; IF/ID flushed per REQ-024; holding buffer discarded.
REQ-026 Redirect state effects: IDLE/HOLD -> REQ; REQ with imem_ready=0 -> stay REQ, new address next cycle; REQ with imem_ready=1 -> WAIT with drop=1.
REQ-027 Redirect in WAIT: without imem_valid -> stay WAIT, drop=1; with imem_valid same cycle -> response discarded, go REQ, drop=0.
REQ-028 WAIT with drop=1 and imem_valid -> response discarded, drop<=0, go REQ; IF/ID and pc untouched.
REQ-029 PC increment is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-030 Fetch stream never skips or duplicates a PC between redirects; IF/ID sequence equals program order.

Reset
REQ-031 While rst_n=0 (asynchronously): state=IDLE, pc=RESET_PC, drop=0, buffer empty, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_pc=RESET_PC, if_id_instr=NOP_INSTR.
REQ-032 Reset asserted mid-request or mid-WAIT abandons the transaction; a late imem_valid after reset release while in IDLE/REQ is ignored.

Verification
REQ-033 Reset release, imem_ready=1, 1-cycle memory returning 0x00A00093 -> imem_addr=0x0 in REQ; IF/ID valid=1, pc=0x0, instr=0x00A00093; next imem_addr=0x4.
REQ-034 stall=1 for 3 cycles while response arrives -> HOLD, IF/ID unchanged, imem_req=0; stall=0 -> IF/ID gets buffered word, next imem_addr=pc+4.
REQ-035 redirect_valid=1, redirect_pc=0x103 in WAIT, response arrives next cycle -> response dropped, if_id_valid=0, next imem_addr=0x100.
REQ-036 bubble=1 and stall=1 together with IF/ID valid -> if_id_valid=0, if_id_instr=0x00000013, pc held.
REQ-037 RESET_PC=32'hFFFF_FFFC, one fetch -> if_id_pc=0xFFFFFFFC, next imem_addr=0x00000000.
REQ-038 rst_n pulsed low during WAIT, imem_valid one cycle after release -> ignored; first IF/ID instruction has pc=RESET_PC.
